bin2seg_scan: RTL
=================

BIN2SEG_SCAN -- requirements
Module: bin2seg_scan

Interface
REQ-001 The block SHALL have parameter BIN_W, default 6, binary input width (1..20).
REQ-002 The block SHALL have parameter DIGITS, default 2, number of decimal digits displayed (1..8).
REQ-003 The block SHALL have parameter SCAN_DIV, default 1000, clk cycles per digit scan slot (>=2).
REQ-004 The block SHALL have port clk, input, 1 bit, the only clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port load, input, 1 bit, request to convert bin_val.
REQ-007 The block SHALL have port bin_val, input, BIN_W bits, unsigned binary value.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-009 The block SHALL have port ovf, output, 1 bit, high when the displayed value exceeds 10^DIGITS-1.
REQ-010 The block SHALL have port seg, output, 7 bits, segments {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-011 The block SHALL have port an, output, DIGITS bits, digit enables, active-low, one-hot-low.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and COMMIT; reset state SHALL be IDLE.
REQ-013 In IDLE, load=1 SHALL capture bin_val, clear the BCD shift register (4*DIGITS bits) and go to SHIFT.
REQ-014 SHIFT SHALL run exactly BIN_W shift-add-3 (double-dabble) cycles, then go to COMMIT.
REQ-015 COMMIT SHALL copy the BCD result and overflow flag to the display register in one cycle, then go to IDLE.
REQ-016 Latency: load sampled at edge N; busy=1 after edges N..N+BIN_W; display register and ovf update at edge N+BIN_W+1; busy=0 after that edge.
REQ-017 load while busy=1 SHALL be ignored, not queued.
REQ-018 Overflow SHALL be detected when the captured value >= 10^DIGITS, using a comparison at least BIN_W+1 bits wide.
REQ-019 When ovf=1, every digit SHALL display a dash (seg=7'b0111111).
REQ-020 Digit patterns SHALL be 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000; BCD 10-15 SHALL display blank (1111111).
REQ-021 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; each wrap SHALL advance the digit index 0..DIGITS-1, wrapping to 0.
REQ-022 seg and an SHALL be registered and SHALL change only on a prescaler wrap; an[i]=0 iff index=i; digit 0 SHALL be the units digit.
REQ-023 When a COMMIT and a scan wrap occur on the same edge, the scan SHALL use the pre-commit display register; new data SHALL appear from the next slot.
REQ-024 When DIGITS=1, the index SHALL stay at 0 and an SHALL be 1'b0 after the first wrap.

Reset
REQ-025 rst=1 SHALL asynchronously force: FSM=IDLE, busy=0, ovf=0, display register=0, prescaler=0, index=0, seg=7'b1111111, an=all ones.
REQ-026 rst asserted mid-conversion SHALL abandon the conversion; the display register SHALL stay 0 until a new load completes.
REQ-027 After reset release, the first prescaler wrap SHALL show "0" on digit 0.

Configuration
REQ-028 Macro LEAD_ZERO_BLANK_EN SHALL, when defined, blank (seg=1111111) every zero digit above the most significant nonzero digit; digit 0 SHALL always be shown; ovf dashes SHALL be unaffected.
REQ-029 Without LEAD_ZERO_BLANK_EN, all DIGITS digits SHALL be shown, including leading zeros.

Verification
REQ-030 BIN_W=6, DIGITS=2, SCAN_DIV=4; load bin_val=59 -> busy high for 7 cycles; digit0 seg=0010000 (9) with an=10; digit1 seg=0010010 (5) with an=01; ovf=0.
REQ-031 BIN_W=7, DIGITS=2; load bin_val=100 -> ovf=1; both digits seg=0111111.
REQ-032 load 37, then load 12 pulsed 2 cycles later (busy) -> the second load is ignored; display shows 37.
REQ-033 Assert rst during SHIFT of load 45 -> immediate seg=1111111, an=11, busy=0; after release the display shows 00 (or " 0" with LEAD_ZERO_BLANK_EN).
REQ-034 With LEAD_ZERO_BLANK_EN and DIGITS=3, load 7 -> digits 2 and 1 blank, digit 0 seg=1111000; load 0 -> only digit 0 shows 1000000.
REQ-035 Align COMMIT with a prescaler wrap -> the old digit is shown for that slot and the new value from the following slot; index wraps 1->0 with no gap.

Source files
------------

// File: rtl/bin2seg_scan.sv
// Binary to multiplexed 7-segment display: double-dabble BCD conversion plus a digit scanner.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits; digit 0 is always shown.
module bin2seg_scan #(
  parameter int BIN_W    = 6,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BIN_W-1:0]  bin_val,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // When 10^DIGITS cannot be reached by a BIN_W-bit value, overflow is impossible.
  localparam longint          POW10        = pow10(DIGITS);
  localparam longint          MAXV         = (longint'(1) << BIN_W) - 1;
  localparam bit              OVF_POSSIBLE = (POW10 <= MAXV);
  localparam logic [BIN_W:0]  LIMIT        = OVF_POSSIBLE ? (BIN_W+1)'(POW10) : '1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_nxt;

  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd, bcd_adj, disp;
  logic [CNT_W-1:0] cnt;
  logic             ovf_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh  <= '0;
      bcd     <= '0;
      cnt     <= '0;
      ovf_cap <= 1'b0;
      disp    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin_sh  <= bin_val;
          bcd     <= '0;
          cnt     <= CNT_W'(BIN_W - 1);
          ovf_cap <= OVF_POSSIBLE && ({1'b0, bin_val} >= LIMIT);
        end
        SHIFT: begin
          {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
          cnt           <= cnt - CNT_W'(1);
        end
        COMMIT: begin
          disp <= bcd;
          ovf  <= ovf_cap;
        end
        default: ;
      endcase
    end
  end

  logic [PS_W-1:0]   presc;
  logic [IDX_W-1:0]  idx;
  logic              wrap;
  logic [3:0]        digit;
  logic              blank;
  logic [DIGITS-1:0] lz;

  assign wrap = (presc == PS_W'(SCAN_DIV - 1));

`ifdef LEAD_ZERO_BLANK_EN
  logic lz_seen;
  always_comb begin
    lz      = '0;
    lz_seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_seen = lz_seen | (disp[4*i +: 4] != 4'd0);
      lz[i]   = ~lz_seen;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    digit = '0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IDX_W'(i)) begin
        digit = disp[4*i +: 4];
        blank = lz[i];
      end
  end

  // disp/ovf read here are pre-commit values when a commit lands on a wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      seg   <= 7'b1111111;
      an    <= '1;
    end else begin
      presc <= wrap ? '0 : presc + PS_W'(1);
      if (wrap) begin
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        an  <= ~(DIGITS'(1) << idx);
        seg <= ovf ? 7'b0111111 : (blank ? 7'b1111111 : seg7(digit));
      end
    end
  end

endmodule
